// File: rtl/game_flow_controller.sv
// Game-state sequencer: start, play, hit-flash, game over, win and a timed restart
// that pulses the synchronous game reset for RESTART_CYCLES clocks.
module game_flow_controller #(
  parameter int HIT_FRAMES     = 60,
  parameter int BLINK_FRAMES   = 8,
  parameter int RESTART_CYCLES = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       keyStart,
  input  logic       lost,
  input  logic [1:0] playerHealth,
  input  logic       aliensAllDead,
  output logic [2:0] gameState,
  output logic       playing,
  output logic       playerVisible,
  output logic       showGameOver,
  output logic       showWin,
  output logic       gameResetN
);

  localparam int FW = $clog2(HIT_FRAMES + 1);
  localparam int CW = $clog2(RESTART_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAYING   = 3'd1,
    HIT       = 3'd2,
    GAME_OVER = 3'd3,
    WIN       = 3'd4,
    RESTART   = 3'd5
  } state_t;

  state_t          state, stateNext;
  logic [FW-1:0]   frameCnt, frameNext, frameInc;
  logic [CW-1:0]   cycCnt, cycNext;
  logic            visible, visibleNext;
  logic            keyPrev;
  logic [1:0]      healthPrev;
  logic            keyPulse;
  logic            healthDrop;

  assign keyPulse   = keyStart & ~keyPrev;
  assign healthDrop = (playerHealth < healthPrev);
  assign frameInc   = frameCnt + FW'(1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      frameCnt   <= '0;
      cycCnt     <= '0;
      visible    <= 1'b1;
      keyPrev    <= 1'b0;
      healthPrev <= 2'd3;
    end else begin
      state    <= stateNext;
      frameCnt <= frameNext;
      cycCnt   <= cycNext;
      visible  <= visibleNext;
      keyPrev  <= keyStart;
      // Health refills while the game blocks are held in reset; that must not look like a drop.
      healthPrev <= (state == RESTART) ? 2'd3 : playerHealth;
    end
  end

  always_comb begin
    stateNext   = state;
    frameNext   = frameCnt;
    cycNext     = cycCnt;
    visibleNext = 1'b1;
    case (state)
      IDLE: begin
        if (keyPulse) stateNext = PLAYING;
      end
      PLAYING: begin
        if (lost) begin
          stateNext = GAME_OVER;
        end else if (aliensAllDead) begin
          stateNext = WIN;
        end else if (healthDrop && (playerHealth != 2'd0)) begin
          stateNext   = HIT;
          frameNext   = '0;
          visibleNext = 1'b0;
        end
      end
      HIT: begin
        visibleNext = visible;
        if (lost) begin
          stateNext   = GAME_OVER;
          visibleNext = 1'b1;
        end else if (startOfFrame) begin
          if (frameCnt >= FW'(HIT_FRAMES - 1)) begin
            stateNext   = PLAYING;
            visibleNext = 1'b1;
          end else begin
            frameNext = frameInc;
            // Blink on every BLINK_FRAMES-th frame boundary of the flash.
            if ((frameInc % FW'(BLINK_FRAMES)) == '0) visibleNext = ~visible;
          end
        end
      end
      GAME_OVER, WIN: begin
        if (keyPulse) begin
          stateNext = RESTART;
          cycNext   = '0;
        end
      end
      RESTART: begin
        if (cycCnt >= CW'(RESTART_CYCLES - 1)) stateNext = IDLE;
        else                                   cycNext   = cycCnt + CW'(1);
      end
      default: stateNext = IDLE;
    endcase
  end

  assign gameState     = state;
  assign playing       = (state == PLAYING);
  assign playerVisible = visible;
  assign showGameOver  = (state == GAME_OVER);
  assign showWin       = (state == WIN);
  assign gameResetN    = (state != RESTART);

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Top-level game-state sequencer directly downstream of the lose detector. It consumes the `lost` flag and the 2-bit `playerHealth` count, plus a win indication and the start key, and runs the game through its screens: start, play, hit-flash, game over and win. It drives freeze/blink controls to the object and drawing blocks, and issues a timed synchronous restart reset to all game-logic blocks (including the lose detector).

Parameters:
HIT_FRAMES, 60, frames the player blinks (game frozen) after losing one health point
BLINK_FRAMES, 8, frames per blink half-period during hit flash
RESTART_CYCLES, 16, clk cycles gameResetN is held low on restart

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per VGA frame
keyStart  in  1  start/restart key level, already debounced, active-high
lost  in  1  level from lose detector: game lost
playerHealth  in  2  remaining health from lose detector (3..0)
aliensAllDead  in  1  level: every alien destroyed
gameState  out  3  encoded state: 0 IDLE, 1 PLAYING, 2 HIT, 3 GAME_OVER, 4 WIN, 5 RESTART
playing  out  1  high only in PLAYING; gates movement, firing and collisions
playerVisible  out  1  player draw enable; toggles during HIT
showGameOver  out  1  high in GAME_OVER
showWin  out  1  high in WIN
gameResetN  out  1  synchronous active-low reset to game blocks

Behaviour:
- Async reset (resetN=0): state IDLE; playing=0, playerVisible=1, showGameOver=0, showWin=0, gameResetN=1; counters 0; healthPrev=3; keyPrev=0.
- All outputs are registered or decoded from the registered state. No combinational path from inputs to outputs.
- keyPulse = keyStart & ~keyPrev. keyPrev updates every cycle.
- healthDrop = (playerHealth < healthPrev), using an unsigned 2-bit compare. healthPrev updates every cycle.
- IDLE: on keyPulse, go to PLAYING.
- PLAYING: transitions are evaluated every cycle, with priority lost > aliensAllDead > healthDrop.
  - lost goes to GAME_OVER.
  - aliensAllDead goes to WIN.
  - healthDrop (with health still nonzero) goes to HIT, clearing frameCnt and setting playerVisible=0.
  - If lost and aliensAllDead are asserted in the same cycle, GAME_OVER wins.
- HIT: playing=0 (freezes the game).
  - frameCnt increments on each startOfFrame.
  - playerVisible toggles each time (frameCnt+1) is a multiple of BLINK_FRAMES.
  - When frameCnt reaches HIT_FRAMES-1 and startOfFrame arrives, go to PLAYING with playerVisible=1.
  - lost during HIT goes immediately to GAME_OVER with playerVisible=1.
  - Further healthDrop during HIT is ignored; play is frozen, so none should occur.
- GAME_OVER and WIN: playing=0 and playerVisible=1; showGameOver or showWin respectively is high.
  - On keyPulse, go to RESTART and clear cycCnt.
- RESTART: gameResetN=0 and playing=0; cycCnt increments every cycle.
  - At cycCnt = RESTART_CYCLES-1, go to IDLE with gameResetN=1.
  - healthPrev is forced to 3 so the health refill is not treated as a drop.
- keyPulse in PLAYING or HIT is ignored.
- gameResetN is asserted low for exactly RESTART_CYCLES cycles per restart.
- Async reset mid-sequence (e.g. during RESTART) returns the block to IDLE with gameResetN=1 immediately.
- Counter widths must hold HIT_FRAMES and RESTART_CYCLES without wrap. Counters saturate and never wrap mid-state.
- startOfFrame pulses outside HIT have no effect.

Test Plan:
1. Reset, pulse keyStart for 1 cycle -> gameState 0->1 on the next edge, playing=1; holding keyStart high for 100 cycles produces only one transition.
2. In PLAYING, drop playerHealth 3->2 -> gameState=2 and playing=0 next cycle; with BLINK_FRAMES=8, playerVisible toggles after frames 8, 16, ...; after 60 startOfFrame pulses, gameState=1 and playerVisible=1.
3. In PLAYING, assert lost and aliensAllDead in the same cycle -> gameState=3, showGameOver=1, showWin=0.
4. In HIT at frame 20, assert lost -> next cycle gameState=3 and playerVisible=1.
5. In WIN, pulse keyStart -> gameResetN low for exactly 16 cycles, then gameState=0; playerHealth returning to 3 during RESTART does not cause a later HIT.
6. Assert resetN=0 mid-RESTART (cycle 5) -> gameResetN=1 and gameState=0 asynchronously, with all outputs at their reset values.
